// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage
// Pipeline register between the 32-bit ALU (execute) and memory/writeback.
// It registers the ALU result, destination index and write enable, keeps the
// committed CPSR flags {N,Z,V}, evaluates a 3-bit branch condition against
// those committed flags, and counts retired (committed valid) instructions.
//
// Ports:
//   clk, reset        clock (rising edge) and async active-high reset
//   in_valid          execute stage presents a real instruction
//   in_alu_out        ALU result
//   in_zout/sout/oout ALU zero / sign / overflow flags
//   in_rd             destination register index
//   in_reg_write      instruction writes a register
//   in_set_flags      instruction updates the CPSR
//   stall, flush      hold stage / discard instruction being captured
//   cond              condition code to evaluate against cpsr
//   out_valid         stage holds a valid instruction
//   out_result        registered ALU result
//   out_rd            registered destination index
//   out_reg_write     registered write enable, gated by out_valid
//   cpsr              committed flags {N,Z,V}
//   cond_pass         combinational result of cond against cpsr
//   retire_cnt        number of committed valid instructions (wraps)

module ex_mem_flag_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_alu_out,
    input  logic               in_zout,
    input  logic               in_sout,
    input  logic               in_oout,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_reg_write,
    input  logic               in_set_flags,
    input  logic               stall,
    input  logic               flush,
    input  logic [2:0]         cond,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_result,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_reg_write,
    output logic [2:0]         cpsr,
    output logic               cond_pass,
    output logic [CNT_W-1:0]   retire_cnt
);

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_MI = 3'b101;
    localparam logic [2:0] COND_PL = 3'b110;
    localparam logic [2:0] COND_VS = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic capture;
    logic flag_n;
    logic flag_z;
    logic flag_v;

    // A real capture happens only when neither flush nor stall is asserted.
    assign capture = ~flush & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            cpsr          <= 3'b000;
            retire_cnt    <= '0;
        end else if (flush) begin
            // Kill the instruction but leave the data registers as they were.
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
        end else if (capture) begin
            out_valid     <= in_valid;
            out_result    <= in_alu_out;
            out_rd        <= in_rd;
            out_reg_write <= in_valid & in_reg_write;
            if (in_valid && in_set_flags) begin
                cpsr <= {in_sout, in_zout, in_oout};
            end
            if (in_valid) begin
                retire_cnt <= retire_cnt + CNT_ONE;
            end
        end
    end

    assign flag_n = cpsr[2];
    assign flag_z = cpsr[1];
    assign flag_v = cpsr[0];

    // Only committed flags are used; the control unit guarantees a bubble
    // between a flag-setter and a dependent branch, so no bypass is needed.
    always_comb begin
        cond_pass = 1'b1;
        unique case (cond)
            COND_AL: cond_pass = 1'b1;
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = ~flag_z;
            COND_LT: cond_pass = flag_n ^ flag_v;
            COND_GE: cond_pass = ~(flag_n ^ flag_v);
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = ~flag_n;
            COND_VS: cond_pass = flag_v;
            default: cond_pass = 1'b1;
        endcase
    end

endmodule
